// File: rtl/invaders_pkg.sv
// Shared types and default geometry for the invader formation block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package invaders_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    CLEARED = 2'd1,
    LANDED  = 2'd2
  } state_t;

  typedef enum logic {
    DIR_UP_COL   = 1'b0,
    DIR_DOWN_COL = 1'b1
  } dir_t;

  localparam int          DEF_COLS        = 20;
  localparam int          DEF_ROWS        = 3;
  localparam int          DEF_X_W         = 5;
  localparam int          DEF_Y_W         = 4;
  localparam logic [19:0] DEF_INIT_ROW    = 20'h001FF;
  localparam int          DEF_INIT_Y      = 1;
  localparam int          DEF_LAND_Y      = 14;
  localparam int unsigned DEF_BASE_PERIOD = 36000000;
  localparam int unsigned DEF_MIN_PERIOD  = 4500000;
  localparam int unsigned DEF_STEP_DEC    = 300000;

endpackage

// File: rtl/invaders_speed_timer.sv
// March-step timer: counts 0..period-1 and pulses o_tick on the terminal count.
// Latency: o_tick is combinational from the count register; period changes apply at the next wrap.
// Backpressure: none; the count simply holds while i_enable is low.
// Ports: i_clk, i_rst_n (async active-low), i_period, i_enable, i_clear (sync), o_tick.
module invaders_speed_timer #(
  parameter logic [31:0] RST_PERIOD = 32'd36000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_period,
  input  logic        i_enable,
  input  logic        i_clear,
  output logic        o_tick
);

  logic [31:0] r_count;
  logic [31:0] r_period;   // period in force for the current lap
  logic        w_last;

  // >= rather than == so a degenerate period of 0 still ticks every cycle
  assign w_last = (r_count + 32'd1) >= r_period;
  assign o_tick = i_enable && w_last && !i_clear;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_period <= RST_PERIOD;
    end else if (i_clear) begin
      r_count  <= '0;
      r_period <= RST_PERIOD;
    end else if (i_enable) begin
      if (w_last) begin
        r_count  <= '0;
        r_period <= i_period;
      end else begin
        r_count <= r_count + 32'd1;
      end
    end
  end

endmodule

// File: rtl/invaders_formation.sv
// Invader formation: ROWS x COLS alive bitmap that marches on a timer, resolves bullet hits, reports cleared/landed.
// Latency: hit applied at the next edge with o_hit one cycle later; cleared/landed flags one cycle after the condition.
// Backpressure: none; bullets are sampled every cycle, the march holds while i_enable is low.
// Ports: i_clk_36MHz, i_reset (async active-low), i_restart, i_enable, i_bullet_valid/x/y,
//        o_invaders_array, o_invaders_row, o_direction, o_hit, o_hit_col, o_cleared, o_landed.
// Option: define INVADERS_SPEEDUP_EN to shorten the march period with every kill.
module invaders_formation
  import invaders_pkg::*;
#(
  parameter int              COLS        = DEF_COLS,
  parameter int              ROWS        = DEF_ROWS,
  parameter int              X_W         = DEF_X_W,
  parameter int              Y_W         = DEF_Y_W,
  parameter logic [COLS-1:0] INIT_ROW    = COLS'(DEF_INIT_ROW),
  parameter int              INIT_Y      = DEF_INIT_Y,
  parameter int              LAND_Y      = DEF_LAND_Y,
  parameter int unsigned     BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int unsigned     MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int unsigned     STEP_DEC    = DEF_STEP_DEC
) (
  input  logic                 i_clk_36MHz,
  input  logic                 i_reset,
  input  logic                 i_restart,
  input  logic                 i_enable,
  input  logic                 i_bullet_valid,
  input  logic [X_W-1:0]       i_bullet_x,
  input  logic [Y_W-1:0]       i_bullet_y,
  output logic [ROWS*COLS-1:0] o_invaders_array,
  output logic [Y_W-1:0]       o_invaders_row,
  output logic                 o_direction,
  output logic                 o_hit,
  output logic [X_W-1:0]       o_hit_col,
  output logic                 o_cleared,
  output logic                 o_landed
);

  localparam int N = ROWS * COLS;

  state_t           r_state;
  dir_t             r_dir;
  logic [N-1:0]     r_rows;
  logic [Y_W-1:0]   r_row;
  logic             r_hit;
  logic [X_W-1:0]   r_hit_col;

  logic [N-1:0]     w_hit_sel;
  logic [N-1:0]     w_hit_bits;
  logic [N-1:0]     w_after;
  logic [N-1:0]     w_marched;
  logic             w_hit;
  logic             w_edge;
  logic             w_tick;
  logic             w_run;
  logic             w_timer_en;
  logic             w_clear_cond;
  logic             w_land_cond;
  logic [Y_W+1:0]   w_bottom;
  logic [31:0]      w_period;

  // Bullet decode: compared per row/column so out-of-range x or y never aliases into a neighbour row.
  always_comb begin
    w_hit_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (i_bullet_valid &&
            ({1'b0, i_bullet_y} == ({1'b0, r_row} + (Y_W+1)'(r))) &&
            (i_bullet_x == X_W'(c)))
          w_hit_sel[r*COLS + c] = 1'b1;
      end
    end
  end

  assign w_hit_bits = w_hit_sel & r_rows;
  assign w_hit      = |w_hit_bits;
  assign w_after    = r_rows & ~w_hit_bits;

  // Edge test and shift both work on the post-hit bitmap.
  always_comb begin
    w_edge    = 1'b0;
    w_marched = w_after;
    for (int r = 0; r < ROWS; r++) begin
      if (r_dir == DIR_UP_COL) begin
        w_edge = w_edge | w_after[r*COLS + COLS - 1];
        w_marched[r*COLS +: COLS] = w_after[r*COLS +: COLS] << 1;
      end else begin
        w_edge = w_edge | w_after[r*COLS];
        w_marched[r*COLS +: COLS] = w_after[r*COLS +: COLS] >> 1;
      end
    end
  end

  // Screen row of the lowest formation row that still has an invader.
  always_comb begin
    w_bottom = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (|r_rows[r*COLS +: COLS])
        w_bottom = (Y_W+2)'(r_row) + (Y_W+2)'(r);
    end
  end

  assign w_clear_cond = (r_rows == '0);
  assign w_land_cond  = (w_bottom >= (Y_W+2)'(LAND_Y));
  // Transition cycles already count as frozen: no hit, no march, timer holds.
  assign w_run        = (r_state == RUN) && !w_clear_cond && !w_land_cond;
  assign w_timer_en   = w_run && i_enable;

`ifdef INVADERS_SPEEDUP_EN
  logic [7:0]  r_kills;
  logic [63:0] w_dec;

  always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
    if (!i_reset)
      r_kills <= '0;
    else if (i_restart)
      r_kills <= '0;
    else if (w_run && w_hit && (r_kills != '1))
      r_kills <= r_kills + 8'd1;
  end

  assign w_dec    = 64'(STEP_DEC) * 64'(r_kills);
  assign w_period = ((w_dec + 64'(MIN_PERIOD)) >= 64'(BASE_PERIOD)) ?
                    32'(MIN_PERIOD) : 32'(64'(BASE_PERIOD) - w_dec);
`else
  assign w_period = 32'(BASE_PERIOD);
`endif

  invaders_speed_timer #(
    .RST_PERIOD (32'(BASE_PERIOD))
  ) u_timer (
    .i_clk    (i_clk_36MHz),
    .i_rst_n  (i_reset),
    .i_period (w_period),
    .i_enable (w_timer_en),
    .i_clear  (i_restart),
    .o_tick   (w_tick)
  );

  always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= RUN;
      r_dir     <= DIR_UP_COL;
      r_rows    <= {ROWS{INIT_ROW}};
      r_row     <= Y_W'(INIT_Y);
      r_hit     <= 1'b0;
      r_hit_col <= '0;
    end else if (i_restart) begin
      r_state   <= RUN;
      r_dir     <= DIR_UP_COL;
      r_rows    <= {ROWS{INIT_ROW}};
      r_row     <= Y_W'(INIT_Y);
      r_hit     <= 1'b0;
      r_hit_col <= '0;
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_clear_cond) begin
            r_state <= CLEARED;
          end else if (w_land_cond) begin
            r_state <= LANDED;
          end else begin
            if (w_hit) begin
              r_hit     <= 1'b1;
              r_hit_col <= i_bullet_x;
            end
            if (w_tick && w_edge) begin
              r_row  <= r_row + 1'b1;
              r_dir  <= (r_dir == DIR_UP_COL) ? DIR_DOWN_COL : DIR_UP_COL;
              r_rows <= w_after;
            end else if (w_tick) begin
              r_rows <= w_marched;
            end else begin
              r_rows <= w_after;
            end
          end
        end
        default: ;   // CLEARED / LANDED hold everything until restart
      endcase
    end
  end

  assign o_invaders_array = r_rows;
  assign o_invaders_row   = r_row;
  assign o_direction      = r_dir;
  assign o_hit            = r_hit;
  assign o_hit_col        = r_hit_col;
  assign o_cleared        = (r_state == CLEARED);
  assign o_landed         = (r_state == LANDED);

endmodule
